txtbuf_arbiter: RTL and testbench

//  Owns the 40x24 text RAM and shares its single port between two requesters:
//  the VDP character fetch, which has fixed priority and fixed latency, and the
//  CPU read/write port, which uses a req/ack handshake. After reset it clears
//  the RAM to the blank glyph. Sits between the CPU bus decode and vdp.

---
 rtl/txtbuf_pkg.sv | 10 +
 rtl/txtbuf_ram.sv | 16 +
 rtl/txtbuf_arbiter.sv | 85 ++++++++
 tb/tb_txtbuf_arbiter.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/txtbuf_pkg.sv
// txtbuf_pkg: shared constants and FSM state type for the text buffer arbiter
package txtbuf_pkg;
  localparam int DEPTH = 960;
  localparam int AW = 10;
  localparam logic [15:0] BASE = 16'h0400;
  localparam logic [7:0] FILL = 8'hA0;
  localparam int STARVE_LIMIT = 64;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [2:0] {CLEAR, IDLE, ACCESS, RDWAIT, ACK} state_t;
endpackage

// File: rtl/txtbuf_ram.sv
// txtbuf_ram: DEPTH x 8 single-port RAM, synchronous read-first, no reset
module txtbuf_ram
  import txtbuf_pkg::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/txtbuf_arbiter.sv
// txtbuf_arbiter: shares the text RAM between fixed-latency VDP fetch and CPU req/ack port
module txtbuf_arbiter
  import txtbuf_pkg::*;
(
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          vdp_rd,
  input  logic [AW-1:0] vdp_adr,
  output logic [7:0]    vdp_data,
  output logic          vdp_valid,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [15:0]   cpu_adr,
  input  logic [7:0]    cpu_wdata,
  output logic [7:0]    cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_err,
  output logic          busy,
  output logic          cpu_starve
);
  state_t state, state_n;
  logic [AW-1:0] ptr, ram_addr;
  logic [SW-1:0] starve_cnt;
  logic [15:0] off;
  logic [7:0] ram_wdata, ram_q, rdata_q;
  logic in_range, grant, blocked, cpu_go, vdp_go, ram_we;
  logic vdp_v1, vdp_fill1, rd_q, err_q;
  assign off = cpu_adr - BASE;
  assign in_range = off < 16'(DEPTH);
  // the CPU only touches the RAM in the cycle it is granted, when vdp_rd is known low
  assign grant = state == IDLE && cpu_req && !vdp_rd;
  assign blocked = state == IDLE && cpu_req && vdp_rd;
  assign cpu_go = grant && in_range;
  assign vdp_go = vdp_rd && state != CLEAR && vdp_adr < AW'(DEPTH);
  assign ram_addr = state == CLEAR ? ptr : vdp_go ? vdp_adr : off[AW-1:0];
  assign ram_we = state == CLEAR || (cpu_go && cpu_we);
  assign ram_wdata = state == CLEAR ? FILL : cpu_wdata;
  assign busy = state == CLEAR;
  assign cpu_ack = state == ACK;
  assign cpu_rdata = cpu_ack ? rdata_q : 8'h00;
  assign cpu_err = cpu_ack && err_q;
  txtbuf_ram u_ram (
    .clk   (CLOCK_50),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );
  always_comb begin
    state_n = state;
    state_n = state == CLEAR  ? (ptr == AW'(DEPTH - 1) ? IDLE : CLEAR) :
              state == IDLE   ? (grant ? ACCESS : IDLE) :
              state == ACCESS ? ACK : IDLE;
  end
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= CLEAR;
      ptr        <= '0;
      starve_cnt <= '0;
      cpu_starve <= 1'b0;
      vdp_v1     <= 1'b0;
      vdp_fill1  <= 1'b0;
      vdp_valid  <= 1'b0;
      vdp_data   <= 8'h00;
      rd_q       <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 8'h00;
    end else begin
      state     <= state_n;
      vdp_v1    <= vdp_rd;
      vdp_fill1 <= !vdp_go;
      vdp_valid <= vdp_v1;
      vdp_data  <= vdp_fill1 ? FILL : ram_q;
      if (state == CLEAR) ptr <= ptr + 1'b1;
      if (grant) begin
        rd_q  <= cpu_go && !cpu_we;
        err_q <= !in_range;
      end
      if (state == ACCESS) rdata_q <= rd_q ? ram_q : 8'h00;
      if (grant) starve_cnt <= '0;
      else if (blocked && starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
      if (blocked && starve_cnt == SW'(STARVE_LIMIT - 1)) cpu_starve <= 1'b1;
    end
  end
endmodule

// File: tb/tb_txtbuf_arbiter.sv
// tb_txtbuf_arbiter: scoreboard bench for txtbuf_arbiter
module tb_txtbuf_arbiter;
  logic CLOCK_50 = 1'b0, reset = 1'b1;
  logic vdp_rd = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [9:0] vdp_adr = '0;
  logic [15:0] cpu_adr = '0;
  logic [7:0] cpu_wdata = '0;
  logic [7:0] vdp_data, cpu_rdata;
  logic vdp_valid, cpu_ack, cpu_err, busy, cpu_starve;
  int n_vec = 0, n_err = 0, cyc = 0;
  typedef struct {int due; logic [7:0] d;} vexp_t;
  typedef struct {int due; logic [7:0] d; logic e;} cexp_t;
  vexp_t vq[$];
  cexp_t cq[$];
  logic [7:0] mem_m [960];
  int m_clr = 960, m_cpu = 0, m_blk = 0;
  logic m_starve = 1'b0;
  txtbuf_arbiter dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .vdp_rd    (vdp_rd),
    .vdp_adr   (vdp_adr),
    .vdp_data  (vdp_data),
    .vdp_valid (vdp_valid),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_adr   (cpu_adr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .cpu_err   (cpu_err),
    .busy      (busy),
    .cpu_starve(cpu_starve)
  );
  always #5 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  // reference model and scoreboard, evaluated mid-cycle when inputs and outputs are stable
  always @(negedge CLOCK_50) begin
    logic [15:0] off;
    logic inr;
    if (reset) begin
      vq.delete();
      cq.delete();
      m_clr = 960;
      m_cpu = 0;
      m_blk = 0;
      m_starve = 1'b0;
      foreach (mem_m[i]) mem_m[i] = 8'hA0;
    end else begin
      check("busy", 16'(busy), 16'(m_clr > 0));
      check("starve", 16'(cpu_starve), 16'(m_starve));
      if (vq.size() > 0 && vq[0].due == cyc) begin
        check("vdp_valid", 16'(vdp_valid), 16'd1);
        check("vdp_data", 16'(vdp_data), 16'(vq[0].d));
        void'(vq.pop_front());
      end else check("vdp_idle", 16'(vdp_valid), 16'd0);
      if (cq.size() > 0 && cq[0].due == cyc) begin
        check("cpu_ack", 16'(cpu_ack), 16'd1);
        check("cpu_rdata", 16'(cpu_rdata), 16'(cq[0].d));
        check("cpu_err", 16'(cpu_err), 16'(cq[0].e));
        void'(cq.pop_front());
      end else check("cpu_noack", 16'(cpu_ack), 16'd0);
      if (vdp_rd) vq.push_back('{cyc + 2, (m_clr > 0 || vdp_adr >= 960) ? 8'hA0 : mem_m[vdp_adr]});
      if (cpu_req && m_clr == 0 && m_cpu == 0) begin
        if (vdp_rd) begin
          m_blk++;
          if (m_blk >= 64) m_starve = 1'b1;
        end else begin
          off = cpu_adr - 16'h0400;
          inr = off < 16'd960;
          cq.push_back('{cyc + 2, (inr && !cpu_we) ? mem_m[off] : 8'h00, !inr});
          if (inr && cpu_we) mem_m[off] = cpu_wdata;
          m_cpu = 3;
          m_blk = 0;
        end
      end
      if (m_clr > 0) m_clr--;
      if (m_cpu > 0) m_cpu--;
    end
  end
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask
  task automatic wait_ack(input bit alt);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      if (cpu_ack) seen = 1'b1;
      else if (alt) begin
        vdp_rd = ~vdp_rd;
        vdp_adr = 10'($urandom_range(0, 1023));
      end
    end
    cpu_req = 1'b0;
    if (alt) vdp_rd = 1'b0;
    check("ack_seen", 16'(seen), 16'd1);
  endtask
  task automatic op(input logic [15:0] adr, input logic we, input logic [7:0] wd, input bit alt);
    cpu_adr = adr;
    cpu_we = we;
    cpu_wdata = wd;
    cpu_req = 1'b1;
    wait_ack(alt);
  endtask
  initial begin
    repeat (3) tick();
    reset = 1'b0;
    vdp_rd = 1'b1;
    vdp_adr = 10'd0;
    repeat (1000) tick();
    vdp_rd = 1'b0;
    tick();
    op(16'h040F, 1'b1, 8'h48, 1'b0);
    op(16'h040F, 1'b0, 8'h00, 1'b0);
    vdp_rd = 1'b1;
    vdp_adr = 10'd15;
    tick();
    vdp_rd = 1'b0;
    repeat (3) tick();
    cpu_adr = 16'h040F;
    cpu_we = 1'b0;
    cpu_req = 1'b1;
    vdp_rd = 1'b1;
    vdp_adr = 10'd3;
    repeat (70) tick();
    check("starve_set", 16'(cpu_starve), 16'd1);
    vdp_rd = 1'b0;
    wait_ack(1'b0);
    tick();
    op(16'h03FF, 1'b0, 8'h00, 1'b0);
    op(16'h07C0, 1'b1, 8'h55, 1'b0);
    op(16'h07BF, 1'b0, 8'h00, 1'b0);
    tick();
    cpu_adr = 16'h0410;
    cpu_we = 1'b1;
    cpu_wdata = 8'h77;
    cpu_req = 1'b1;
    tick();
    reset = 1'b1;
    cpu_req = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 1100 && busy; i++) tick();
    check("clear_done", 16'(busy), 16'd0);
    op(16'h0410, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) op(16'h0400 + 16'(i * 37), 1'b1, 8'(8'h10 + i * 13), 1'b1);
    for (int i = 0; i < 8; i++) op(16'h0400 + 16'(i * 37), 1'b0, 8'h00, 1'b1);
    repeat (5) tick();
    check("vq_drain", 16'(vq.size()), 16'd0);
    check("cq_drain", 16'(cq.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
